// File: rtl/fir_xifu_pkg.sv
// Shared types for the FIR XIFU execute stage: opcodes, FSM states, EX stage records.
package fir_xifu_pkg;

  typedef enum logic [1:0] {
    OpNop  = 2'd0,
    OpDotp = 2'd1,
    OpLw   = 2'd2,
    OpSw   = 2'd3
  } fir_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StMem,
    StOut
  } fir_state_e;

  typedef struct packed {
    fir_op_e     instr;
    logic [4:0]  rd;
    logic [31:0] op_a;
    logic [31:0] op_b;
  } ex_in_t;

  typedef struct packed {
    fir_op_e    instr;
    logic [4:0] rd;
  } ex_out_t;

  // Base plus signed offset; wraps modulo 2^32.
  function automatic logic [31:0] agu_addr(input logic [31:0] base, input logic [31:0] off);
    return base + off;
  endfunction

endpackage

// File: rtl/fir_xifu_dotp.sv
// N-lane signed dot product plus accumulator, optional post-multiply register stage.
// Saturation to the signed ACC_W range is enabled by defining FIR_XIFU_SAT_EN.
module fir_xifu_dotp #(
  parameter int unsigned NUM_LANES  = 2,
  parameter int unsigned LANE_W     = 16,
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned MUL_STAGES = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_en,
  input  logic [31:0]      i_a,
  input  logic [31:0]      i_b,
  input  logic [ACC_W-1:0] i_c,
  output logic [ACC_W-1:0] o_result
);

  localparam int unsigned SumW = 2 * LANE_W + $clog2(NUM_LANES) + 1;
  localparam int unsigned ExtW = ((SumW > ACC_W) ? SumW : ACC_W) + 1;

  logic signed [2*LANE_W-1:0] w_prod [NUM_LANES];
  logic signed [SumW-1:0]     w_sum;
  logic signed [SumW-1:0]     w_sum_stg;
  logic signed [ExtW-1:0]     w_total;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign w_prod[g] = (2*LANE_W)'($signed(i_a[g*LANE_W +: LANE_W]))
                     * (2*LANE_W)'($signed(i_b[g*LANE_W +: LANE_W]));
  end

  always_comb begin
    w_sum = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      w_sum = w_sum + SumW'(w_prod[i]);
    end
  end

  if (MUL_STAGES != 0) begin : g_pipe
    logic signed [SumW-1:0] r_sum;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_sum <= '0;
      end else if (i_en) begin
        r_sum <= w_sum;
      end
    end
    assign w_sum_stg = r_sum;
  end else begin : g_comb
    logic w_unused_pipe;
    assign w_unused_pipe = clk_i ^ rst_ni ^ i_en;
    assign w_sum_stg     = w_sum;
  end

  // Accumulator is only sampled in the output cycle, so it need not be pipelined.
  assign w_total = ExtW'(w_sum_stg) + ExtW'($signed(i_c));

`ifdef FIR_XIFU_SAT_EN
  localparam logic signed [ExtW-1:0] SatMax = ExtW'({1'b0, {(ACC_W-1){1'b1}}});
  localparam logic signed [ExtW-1:0] SatMin = ~SatMax;

  always_comb begin
    if (w_total > SatMax) begin
      o_result = SatMax[ACC_W-1:0];
    end else if (w_total < SatMin) begin
      o_result = SatMin[ACC_W-1:0];
    end else begin
      o_result = w_total[ACC_W-1:0];
    end
  end
`else
  logic w_unused_hi;
  assign w_unused_hi = ^w_total[ExtW-1:ACC_W];
  assign o_result    = w_total[ACC_W-1:0];
`endif

endmodule

// File: rtl/fir_xifu_ex_simd.sv
// FIR XIFU execute stage: SIMD dot product and post-increment load/store issue.
// Define FIR_XIFU_SAT_EN to saturate dot-product results instead of wrapping.
module fir_xifu_ex_simd
  import fir_xifu_pkg::*;
#(
  parameter int unsigned NUM_LANES  = 2,
  parameter int unsigned LANE_W     = 16,
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned MUL_STAGES = 0,
  parameter int unsigned ID_W       = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       in_instr_i,
  input  logic [ID_W-1:0]  in_id_i,
  input  logic [4:0]       in_rd_i,
  input  logic [31:0]      in_op_a_i,
  input  logic [31:0]      in_op_b_i,
  input  logic [ACC_W-1:0] in_op_c_i,
  output logic             mem_valid_o,
  input  logic             mem_ready_i,
  output logic [ID_W-1:0]  mem_id_o,
  output logic [31:0]      mem_addr_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_wdata_o,
  output logic [3:0]       mem_be_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [1:0]       out_instr_o,
  output logic [4:0]       out_rd_o,
  output logic [ACC_W-1:0] out_result_o
);

  fir_state_e       r_state;
  fir_state_e       w_state_nxt;
  ex_in_t           r_in;
  logic [ID_W-1:0]  r_id;
  logic [ACC_W-1:0] r_op_c;
  logic             w_accept;
  logic [31:0]      w_addr;
  logic [ACC_W-1:0] w_dotp;
  ex_out_t          w_out;

  // An accept may coincide with the WB handshake, giving one result per cycle.
  always_comb begin
    case (r_state)
      StIdle:  in_ready_o = 1'b1;
      StOut:   in_ready_o = out_ready_i;
      default: in_ready_o = 1'b0;
    endcase
  end

  assign w_accept = in_valid_i & in_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle, StOut: begin
        if (r_state == StOut && out_ready_i) w_state_nxt = StIdle;
        if (w_accept) begin
          case (fir_op_e'(in_instr_i))
            OpDotp:     w_state_nxt = (MUL_STAGES != 0) ? StMul : StOut;
            OpLw, OpSw: w_state_nxt = StMem;
            default:    ;
          endcase
        end
      end
      StMul:   w_state_nxt = StOut;
      StMem:   if (mem_ready_i) w_state_nxt = StOut;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_in   <= '0;
      r_id   <= '0;
      r_op_c <= '0;
    end else if (w_accept) begin
      r_in   <= '{instr: fir_op_e'(in_instr_i), rd: in_rd_i, op_a: in_op_a_i, op_b: in_op_b_i};
      r_id   <= in_id_i;
      r_op_c <= in_op_c_i;
    end
  end

  fir_xifu_dotp #(
    .NUM_LANES  (NUM_LANES),
    .LANE_W     (LANE_W),
    .ACC_W      (ACC_W),
    .MUL_STAGES (MUL_STAGES)
  ) u_dotp (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .i_en     (r_state == StMul),
    .i_a      (r_in.op_a),
    .i_b      (r_in.op_b),
    .i_c      (r_op_c),
    .o_result (w_dotp)
  );

  assign w_addr = agu_addr(r_in.op_a, r_in.op_b);

  always_comb begin
    mem_valid_o  = (r_state == StMem);
    mem_id_o     = r_id;
    mem_addr_o   = w_addr;
    mem_we_o     = (r_in.instr == OpSw);
    mem_wdata_o  = r_op_c[31:0];
    mem_be_o     = mem_valid_o ? 4'b1111 : 4'b0000;
    out_valid_o  = (r_state == StOut);
    w_out        = '{instr: r_in.instr, rd: r_in.rd};
    out_instr_o  = w_out.instr;
    out_rd_o     = w_out.rd;
    case (r_in.instr)
      OpDotp:     out_result_o = w_dotp;
      OpLw, OpSw: out_result_o = ACC_W'(w_addr + 32'd4);
      default:    out_result_o = '0;
    endcase
  end

endmodule

// File: tb/tb_fir_xifu_ex_simd.sv
// Scoreboard bench for fir_xifu_ex_simd: default 2x16 instance plus a 4x8, one-stage instance.
module tb_fir_xifu_ex_simd;

  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_DOTP = 2'd1;
  localparam logic [1:0] OP_LW = 2'd2;
  localparam logic [1:0] OP_SW = 2'd3;

  typedef struct packed {
    logic [1:0]  instr;
    logic [4:0]  rd;
    logic [31:0] res;
  } out_rec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  id;
  } mem_rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, mem_valid, mem_ready, mem_we, out_valid, out_ready;
  logic [1:0]  in_instr, out_instr;
  logic [3:0]  in_id, mem_id, mem_be;
  logic [4:0]  in_rd, out_rd;
  logic [31:0] in_a, in_b, in_c, mem_addr, mem_wdata, out_result;

  logic        s4_in_valid, s4_in_ready, s4_mem_valid, s4_mem_we, s4_out_valid;
  logic [1:0]  s4_out_instr;
  logic [3:0]  s4_mem_id, s4_mem_be;
  logic [4:0]  s4_out_rd;
  logic [31:0] s4_a, s4_b, s4_c, s4_mem_addr, s4_mem_wdata, s4_out_result;

  int n_checks = 0;
  int n_errors = 0;
  int mem_delay = 0;
  bit bp_rand = 1'b0;
  out_rec_t q_out[$];
  mem_rec_t q_mem[$];
  logic [3:0] id_cnt = 4'd0;

  fir_xifu_ex_simd dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_instr_i(in_instr), .in_id_i(in_id),
    .in_rd_i(in_rd), .in_op_a_i(in_a), .in_op_b_i(in_b), .in_op_c_i(in_c),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_id_o(mem_id), .mem_addr_o(mem_addr),
    .mem_we_o(mem_we), .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_instr_o(out_instr),
    .out_rd_o(out_rd), .out_result_o(out_result)
  );

  fir_xifu_ex_simd #(.NUM_LANES(4), .LANE_W(8), .ACC_W(32), .MUL_STAGES(1), .ID_W(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(s4_in_valid), .in_ready_o(s4_in_ready), .in_instr_i(OP_DOTP), .in_id_i(4'd0),
    .in_rd_i(5'd3), .in_op_a_i(s4_a), .in_op_b_i(s4_b), .in_op_c_i(s4_c),
    .mem_valid_o(s4_mem_valid), .mem_ready_i(1'b0), .mem_id_o(s4_mem_id),
    .mem_addr_o(s4_mem_addr), .mem_we_o(s4_mem_we), .mem_wdata_o(s4_mem_wdata),
    .mem_be_o(s4_mem_be), .out_valid_o(s4_out_valid), .out_ready_i(1'b1),
    .out_instr_o(s4_out_instr), .out_rd_o(s4_out_rd), .out_result_o(s4_out_result)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_dotp(input int lanes, input int w,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c);
    longint s, x, y;
    s = longint'($signed(c));
    for (int i = 0; i < lanes; i++) begin
      x = longint'(a >> (i * w));
      x = (x <<< (64 - w)) >>> (64 - w);
      y = longint'(b >> (i * w));
      y = (y <<< (64 - w)) >>> (64 - w);
      s = s + x * y;
    end
`ifdef FIR_XIFU_SAT_EN
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
    return s[31:0];
  endfunction

  // Called and returns just after a rising edge.
  task automatic issue(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c);
    int n;
    logic [31:0] addr;
    n = 0;
    addr = a + b;
    in_valid = 1'b1; in_instr = op; in_rd = rd; in_a = a; in_b = b; in_c = c; in_id = id_cnt;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", {63'd0, in_ready}, 64'd1);
    end else begin
      if (op == OP_DOTP) q_out.push_back('{instr: op, rd: rd, res: model_dotp(2, 16, a, b, c)});
      if (op == OP_LW || op == OP_SW) begin
        q_out.push_back('{instr: op, rd: rd, res: addr + 32'd4});
        q_mem.push_back('{addr: addr, we: (op == OP_SW), wdata: c, id: id_cnt});
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    id_cnt = id_cnt + 4'd1;
  endtask

  task automatic run4(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                      input logic [31:0] exp);
    int n;
    n = 0;
    s4_in_valid = 1'b1; s4_a = a; s4_b = b; s4_c = c;
    @(negedge clk);
    while (!s4_in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("d4_accept", {63'd0, s4_in_ready}, 64'd1);
    @(posedge clk);
    #1;
    s4_in_valid = 1'b0;
    @(negedge clk);
    check("d4_mul_out_valid", {63'd0, s4_out_valid}, 64'd0);
    check("d4_mul_in_ready", {63'd0, s4_in_ready}, 64'd0);
    @(negedge clk);
    check("d4_out_valid", {63'd0, s4_out_valid}, 64'd1);
    check("d4_result", {32'd0, s4_out_result}, {32'd0, exp});
    @(posedge clk);
    #1;
  endtask

  // Memory responder: accepts a request after mem_delay waiting cycles.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    mem_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_valid && !mem_ready) begin
        wait_cnt++;
        mem_ready = (wait_cnt > mem_delay);
      end else begin
        wait_cnt = 0;
        mem_ready = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_rand) out_ready = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q_out.size() == 0) begin
        check("sb_out_unexpected", {32'd0, out_result}, 64'd0 - 64'd1);
      end else begin
        out_rec_t e;
        e = q_out.pop_front();
        check("sb_out_instr", {62'd0, out_instr}, {62'd0, e.instr});
        check("sb_out_rd", {59'd0, out_rd}, {59'd0, e.rd});
        check("sb_out_result", {32'd0, out_result}, {32'd0, e.res});
      end
    end
    if (rst_n && mem_valid && mem_ready) begin
      if (q_mem.size() == 0) begin
        check("sb_mem_unexpected", {32'd0, mem_addr}, 64'd0 - 64'd1);
      end else begin
        mem_rec_t m;
        m = q_mem.pop_front();
        check("sb_mem_addr", {32'd0, mem_addr}, {32'd0, m.addr});
        check("sb_mem_we", {63'd0, mem_we}, {63'd0, m.we});
        check("sb_mem_wdata", {32'd0, mem_wdata}, {32'd0, m.wdata});
        check("sb_mem_id", {60'd0, mem_id}, {60'd0, m.id});
        check("sb_mem_be", {60'd0, mem_be}, 64'hF);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] sat_exp;
    logic [1:0]  op;
    logic [31:0] ra, rb, rc;
    logic [7:0]  roff;
    in_valid = 1'b0; in_instr = OP_NOP; in_id = '0; in_rd = '0;
    in_a = '0; in_b = '0; in_c = '0; out_ready = 1'b1;
    s4_in_valid = 1'b0; s4_a = '0; s4_b = '0; s4_c = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
    check("rst_out_result", {32'd0, out_result}, 64'd0);
    check("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    check("rst_d4_out_valid", {63'd0, s4_out_valid}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // DOTP with one-cycle latency
    issue(OP_DOTP, 5'd1, 32'h0003_FFFE, 32'h0004_0005, 32'd10);
    @(negedge clk);
    check("t1_out_valid", {63'd0, out_valid}, 64'd1);
    check("t1_result", {32'd0, out_result}, 64'd12);
    @(posedge clk);
    #1;

    // Four-lane, one extra stage
    run4(32'h7F7F_7F7F, 32'h7F7F_7F7F, 32'd0, 32'h0000_FC04);
    for (int k = 0; k < 4; k++) begin
      ra = $urandom; rb = $urandom; rc = $urandom;
      run4(ra, rb, rc, model_dotp(4, 8, ra, rb, rc));
    end

    // LW with a delayed memory accept
    mem_delay = 3;
    issue(OP_LW, 5'd2, 32'h0000_1000, 32'hFFFF_FFF8, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_wait_mem_valid", {63'd0, mem_valid}, 64'd1);
      check("t3_wait_addr", {32'd0, mem_addr}, 64'h0FF8);
      check("t3_wait_we", {63'd0, mem_we}, 64'd0);
      check("t3_wait_in_ready", {63'd0, in_ready}, 64'd0);
      check("t3_wait_out_valid", {63'd0, out_valid}, 64'd0);
    end
    @(negedge clk);
    check("t3_hs", {62'd0, mem_valid, mem_ready}, 64'd3);
    @(negedge clk);
    check("t3_out_valid", {63'd0, out_valid}, 64'd1);
    check("t3_result", {32'd0, out_result}, 64'h0FFC);
    @(posedge clk);
    #1;
    mem_delay = 0;

    // Back-pressure on four back-to-back DOTPs
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          issue(OP_DOTP, 5'(k + 4), 32'h0001_0000 + 32'(k + 1), 32'h0002_0003, 32'(k * 100));
        end
      end
      begin
        @(posedge clk);
        repeat (2) begin
          @(negedge clk);
          check("t4_hold_in_ready", {63'd0, in_ready}, 64'd0);
          check("t4_hold_out_valid", {63'd0, out_valid}, 64'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Saturation corners
`ifdef FIR_XIFU_SAT_EN
    sat_exp = 32'h7FFF_FFFF;
`else
    sat_exp = 32'h8000_0001;
`endif
    issue(OP_DOTP, 5'd20, 32'h0001_0001, 32'h0001_0001, 32'h7FFF_FFFF);
    @(negedge clk);
    check("t5_sat_pos", {32'd0, out_result}, {32'd0, sat_exp});
    @(posedge clk);
    #1;
    issue(OP_DOTP, 5'd21, 32'h8000_8000, 32'h8000_8000, 32'h7FFF_FFFF);
    issue(OP_DOTP, 5'd22, 32'h0001_FFFF, 32'h0000_0001, 32'h8000_0000);
    issue(OP_NOP, 5'd23, 32'h1234_5678, 32'h1, 32'h2);

    // Random mix with random stalls
    bp_rand = 1'b1;
    for (int k = 0; k < 40; k++) begin
      op = 2'($urandom_range(0, 3));
      mem_delay = $urandom_range(0, 2);
      ra = $urandom; rb = $urandom; rc = $urandom; roff = 8'($urandom);
      if (op == OP_LW || op == OP_SW) rb = {{24{roff[7]}}, roff};
      issue(op, 5'($urandom), ra, rb, rc);
    end
    bp_rand = 1'b0;
    out_ready = 1'b1;
    mem_delay = 0;
    repeat (10) @(posedge clk);
    #1;

    // Reset in the middle of a store
    mem_delay = 5;
    issue(OP_SW, 5'd9, 32'h0000_2000, 32'h4, 32'hDEAD_BEEF);
    @(negedge clk);
    check("t6_pre_mem_valid", {63'd0, mem_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_mem_valid", {63'd0, mem_valid}, 64'd0);
    check("t6_rst_out_valid", {63'd0, out_valid}, 64'd0);
    q_out.delete();
    q_mem.delete();
    @(negedge clk);
    rst_n = 1'b1;
    mem_delay = 0;
    @(posedge clk);
    #1;
    issue(OP_SW, 5'd10, 32'hFFFF_FFF8, 32'h4, 32'h1234_5678);
    @(negedge clk);
    check("t6_new_mem_addr", {32'd0, mem_addr}, 64'hFFFF_FFFC);
    check("t6_new_mem_we", {63'd0, mem_we}, 64'd1);
    @(negedge clk);
    check("t6_new_out_valid", {63'd0, out_valid}, 64'd1);
    check("t6_wrap_result", {32'd0, out_result}, 64'd0);

    repeat (10) @(negedge clk);
    check("sb_out_drain", 64'(q_out.size()), 64'd0);
    check("sb_mem_drain", 64'(q_mem.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
